// File: rtl/cork_seal_controller.sv
// Sealing-station sequencer around the cork counter: presses each bottle, issues one
// decrement per bottle, services operator refills with a saturated load, halts when empty.
module cork_seal_controller #(
  parameter int WIDTH       = 7,
  parameter int MAX_CORKS   = 99,
  parameter int LOW_THRESH  = 5,
  parameter int SEAL_CYCLES = 4
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             BOTTLE_PRESENT,
  input  logic             REFILL_REQ,
  input  logic [WIDTH-1:0] REFILL_QTY,
  input  logic [WIDTH-1:0] COUNT,
  input  logic             ZERO,
  output logic             ENABLE,
  output logic             LOAD,
  output logic [WIDTH-1:0] DADOS,
  output logic             PRESS,
  output logic             BOTTLE_RELEASE,
  output logic             LOW_STOCK,
  output logic             HALT
);

  localparam int TW = $clog2(SEAL_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    SEAL,
    CONSUME,
    WAIT_CLEAR,
    STALL,
    REFILL
  } state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic             pending, pending_nxt;
  logic [WIDTH-1:0] qty, qty_nxt;
  logic [WIDTH-1:0] dados_q, dados_nxt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sat;

  // Sum is one bit wider so a wrap can never masquerade as a small value.
  always_comb begin
    sum = {1'b0, COUNT} + {1'b0, qty};
    sat = (sum > (WIDTH+1)'(MAX_CORKS)) ? WIDTH'(MAX_CORKS) : sum[WIDTH-1:0];
  end

  assign LOW_STOCK = (COUNT <= WIDTH'(LOW_THRESH)) && !ZERO;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state   <= IDLE;
      timer   <= '0;
      pending <= 1'b0;
      qty     <= '0;
      dados_q <= '0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      pending <= pending_nxt;
      qty     <= qty_nxt;
      dados_q <= dados_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    timer_nxt      = '0;
    pending_nxt    = pending;
    qty_nxt        = qty;
    dados_nxt      = dados_q;
    ENABLE         = 1'b0;
    LOAD           = 1'b0;
    DADOS          = dados_q;
    PRESS          = 1'b0;
    BOTTLE_RELEASE = 1'b0;
    HALT           = 1'b0;

    // Any request outside REFILL latches the newest quantity; REFILL clears pending.
    if (REFILL_REQ && state != REFILL) begin
      qty_nxt     = REFILL_QTY;
      pending_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        if (pending || REFILL_REQ)        state_nxt = REFILL;
        else if (BOTTLE_PRESENT && ZERO)  state_nxt = STALL;
        else if (BOTTLE_PRESENT)          state_nxt = SEAL;
      end
      SEAL: begin
        PRESS = 1'b1;
        if (timer == TW'(SEAL_CYCLES - 1)) state_nxt = CONSUME;
        else                               timer_nxt = timer + TW'(1);
      end
      CONSUME: begin
        ENABLE         = 1'b1;
        BOTTLE_RELEASE = 1'b1;
        state_nxt      = WAIT_CLEAR;
      end
      WAIT_CLEAR: begin
        if (!BOTTLE_PRESENT) state_nxt = IDLE;
      end
      STALL: begin
        HALT = 1'b1;
        if (REFILL_REQ)           state_nxt = REFILL;
        else if (!BOTTLE_PRESENT) state_nxt = IDLE;
      end
      REFILL: begin
        pending_nxt = 1'b0;
        state_nxt   = IDLE;
        if (qty != '0) begin
          LOAD      = 1'b1;
          DADOS     = sat;
          dados_nxt = sat;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cork_seal_controller.sv
// Bench for cork_seal_controller: a behavioural cork counter closes the loop, and
// expected ENABLE/LOAD pulses are queued and matched as the DUT emits them.
module tb_cork_seal_controller;

  localparam int W = 7;

  logic         CLOCK = 1'b0;
  logic         RESET = 1'b1;
  logic         BOTTLE_PRESENT = 1'b0;
  logic         REFILL_REQ = 1'b0;
  logic [W-1:0] REFILL_QTY = '0;
  logic [W-1:0] cnt;
  logic         ZERO;
  logic         ENABLE, LOAD, PRESS, BOTTLE_RELEASE, LOW_STOCK, HALT;
  logic [W-1:0] DADOS;

  logic         set_req = 1'b0;
  logic [W-1:0] set_val = '0;

  typedef struct packed {
    logic         is_load;
    logic [W-1:0] val;
  } ev_t;
  ev_t sbq[$];

  int errors = 0;
  int checks = 0;

  cork_seal_controller #(
    .WIDTH(W), .MAX_CORKS(99), .LOW_THRESH(5), .SEAL_CYCLES(4)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .BOTTLE_PRESENT(BOTTLE_PRESENT),
    .REFILL_REQ(REFILL_REQ), .REFILL_QTY(REFILL_QTY), .COUNT(cnt), .ZERO(ZERO),
    .ENABLE(ENABLE), .LOAD(LOAD), .DADOS(DADOS), .PRESS(PRESS),
    .BOTTLE_RELEASE(BOTTLE_RELEASE), .LOW_STOCK(LOW_STOCK), .HALT(HALT)
  );

  always #5 CLOCK = ~CLOCK;

  // Cork counter the controller drives.
  always @(posedge CLOCK) begin
    if (set_req)     cnt <= set_val;
    else if (LOAD)   cnt <= DADOS;
    else if (ENABLE) cnt <= cnt - 1'b1;
  end
  assign ZERO = (cnt == '0);

  task automatic push_ev(input logic l, input logic [W-1:0] v);
    ev_t e;
    e.is_load = l;
    e.val     = v;
    sbq.push_back(e);
  endtask

  task automatic tick();
    ev_t e;
    @(posedge CLOCK);
    #1;
    checks++;
    if (ENABLE && LOAD) begin
      errors++;
      $display("FAIL enable_load_overlap ENABLE=%0b LOAD=%0b required not both high", ENABLE, LOAD);
    end
    if (ENABLE || LOAD) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse ENABLE=%0b LOAD=%0b DADOS=%0d COUNT=%0d required no pulse",
                 ENABLE, LOAD, DADOS, cnt);
      end else begin
        e = sbq.pop_front();
        if (LOAD !== e.is_load || (LOAD ? DADOS : cnt) !== e.val) begin
          errors++;
          $display("FAIL scoreboard got load=%0b val=%0d required load=%0b val=%0d",
                   LOAD, LOAD ? DADOS : cnt, e.is_load, e.val);
        end
      end
    end
  endtask

  task automatic apply_reset(input logic [W-1:0] v);
    sbq.delete();
    RESET = 1'b1; set_req = 1'b1; set_val = v;
    BOTTLE_PRESENT = 1'b0; REFILL_REQ = 1'b0; REFILL_QTY = '0;
    tick();
    set_req = 1'b0;
    tick();
    RESET = 1'b0;
  endtask

  task automatic seal_bottle(input logic [W-1:0] exp_pre, output int press_n,
                             output bit got, output logic rel);
    push_ev(1'b0, exp_pre);
    BOTTLE_PRESENT = 1'b1;
    press_n = 0; got = 0; rel = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      if (PRESS) press_n++;
      if (ENABLE) begin got = 1; rel = BOTTLE_RELEASE; end
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s_drained pending=%0d required 0", name, sbq.size());
    end
  endtask

  task automatic test_reset();
    apply_reset(7'd99);
    checks++;
    if ({ENABLE, LOAD, PRESS, BOTTLE_RELEASE, HALT} !== 5'b0 || DADOS !== '0 || cnt !== 7'd99) begin
      errors++;
      $display("FAIL reset_state en=%0b ld=%0b pr=%0b rel=%0b halt=%0b dados=%0d count=%0d required zeros, count=99",
               ENABLE, LOAD, PRESS, BOTTLE_RELEASE, HALT, DADOS, cnt);
    end
  endtask

  task automatic test_single_seal();
    int n; bit got; logic rel;
    apply_reset(7'd99);
    seal_bottle(7'd99, n, got, rel);
    checks++;
    if (got !== 1'b1 || n != 4 || rel !== 1'b1) begin
      errors++;
      $display("FAIL seal_sequence got=%0b press=%0d rel=%0b required 1, 4, 1", got, n, rel);
    end
    repeat (8) tick();
    checks++;
    if (cnt !== 7'd98 || PRESS !== 1'b0) begin
      errors++;
      $display("FAIL seal_once count=%0d press=%0b required 98, 0", cnt, PRESS);
    end
    BOTTLE_PRESENT = 1'b0;
    tick(); tick();
    seal_bottle(7'd98, n, got, rel);
    BOTTLE_PRESENT = 1'b0;
    tick(); tick();
    checks++;
    if (got !== 1'b1 || n != 4 || cnt !== 7'd97) begin
      errors++;
      $display("FAIL second_bottle got=%0b press=%0d count=%0d required 1, 4, 97", got, n, cnt);
    end
    check_drained("single_seal");
  endtask

  task automatic test_stall();
    int n; bit got; logic rel;
    apply_reset(7'd0);
    BOTTLE_PRESENT = 1'b1;
    repeat (10) tick();
    checks++;
    if (HALT !== 1'b1 || PRESS !== 1'b0 || LOW_STOCK !== 1'b0) begin
      errors++;
      $display("FAIL stall halt=%0b press=%0b low=%0b required 1, 0, 0", HALT, PRESS, LOW_STOCK);
    end
    push_ev(1'b1, 7'd30);
    REFILL_REQ = 1'b1; REFILL_QTY = 7'd30;
    tick();
    checks++;
    if (LOAD !== 1'b1 || DADOS !== 7'd30) begin
      errors++;
      $display("FAIL stall_refill load=%0b dados=%0d required 1, 30", LOAD, DADOS);
    end
    REFILL_REQ = 1'b0; REFILL_QTY = '0;
    tick();
    checks++;
    if (HALT !== 1'b0 || cnt !== 7'd30) begin
      errors++;
      $display("FAIL stall_exit halt=%0b count=%0d required 0, 30", HALT, cnt);
    end
    seal_bottle(7'd30, n, got, rel);
    tick();
    checks++;
    if (got !== 1'b1 || cnt !== 7'd29) begin
      errors++;
      $display("FAIL stall_then_seal got=%0b count=%0d required 1, 29", got, cnt);
    end
    BOTTLE_PRESENT = 1'b0;
    tick(); tick();
    check_drained("stall");
  endtask

  task automatic do_refill(input logic [W-1:0] start, input logic [W-1:0] q,
                           input logic [W-1:0] exp_final, input logic exp_load);
    apply_reset(start);
    if (exp_load) push_ev(1'b1, exp_final);
    REFILL_REQ = 1'b1; REFILL_QTY = q;
    tick();
    REFILL_REQ = 1'b0; REFILL_QTY = '0;
    checks++;
    if (LOAD !== exp_load) begin
      errors++;
      $display("FAIL refill_load start=%0d qty=%0d load=%0b required %0b", start, q, LOAD, exp_load);
    end
    tick(); tick();
    checks++;
    if (cnt !== exp_final) begin
      errors++;
      $display("FAIL refill_count start=%0d qty=%0d count=%0d required %0d", start, q, cnt, exp_final);
    end
    check_drained("refill");
  endtask

  task automatic test_saturation();
    do_refill(7'd90, 7'd20,  7'd99, 1'b1);
    do_refill(7'd99, 7'd127, 7'd99, 1'b1);
    do_refill(7'd40, 7'd0,   7'd40, 1'b0);
    do_refill(7'd10, 7'd5,   7'd15, 1'b1);
  endtask

  task automatic test_refill_during_seal();
    bit got;
    apply_reset(7'd50);
    push_ev(1'b0, 7'd50);
    BOTTLE_PRESENT = 1'b1;
    tick(); tick();
    REFILL_REQ = 1'b1; REFILL_QTY = 7'd10;
    tick();
    REFILL_REQ = 1'b0; REFILL_QTY = '0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (ENABLE) got = 1;
    end
    repeat (3) tick();
    checks++;
    if (got !== 1'b1 || cnt !== 7'd49) begin
      errors++;
      $display("FAIL deferred_seal got=%0b count=%0d required 1, 49", got, cnt);
    end
    BOTTLE_PRESENT = 1'b0;
    push_ev(1'b1, 7'd59);
    tick();
    checks++;
    if (LOAD !== 1'b0) begin
      errors++;
      $display("FAIL deferred_early load=%0b required 0", LOAD);
    end
    tick();
    checks++;
    if (LOAD !== 1'b1 || DADOS !== 7'd59) begin
      errors++;
      $display("FAIL deferred_load load=%0b dados=%0d required 1, 59", LOAD, DADOS);
    end
    tick();
    checks++;
    if (cnt !== 7'd59) begin
      errors++;
      $display("FAIL deferred_count count=%0d required 59", cnt);
    end
    check_drained("deferred");
  endtask

  task automatic test_low_stock();
    logic [W-1:0] vals[4] = '{7'd5, 7'd1, 7'd6, 7'd0};
    logic         exps[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      apply_reset(vals[i]);
      checks++;
      if (LOW_STOCK !== exps[i]) begin
        errors++;
        $display("FAIL low_stock count=%0d low=%0b required %0b", vals[i], LOW_STOCK, exps[i]);
      end
    end
    BOTTLE_PRESENT = 1'b1;
    tick(); tick();
    checks++;
    if (HALT !== 1'b1 || LOW_STOCK !== 1'b0) begin
      errors++;
      $display("FAIL low_stock_empty halt=%0b low=%0b required 1, 0", HALT, LOW_STOCK);
    end
    BOTTLE_PRESENT = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_seal();
    apply_reset(7'd20);
    BOTTLE_PRESENT = 1'b1;
    tick(); tick();
    checks++;
    if (PRESS !== 1'b1) begin
      errors++;
      $display("FAIL mid_seal_press press=%0b required 1", PRESS);
    end
    RESET = 1'b1; BOTTLE_PRESENT = 1'b0;
    tick();
    checks++;
    if (PRESS !== 1'b0 || ENABLE !== 1'b0) begin
      errors++;
      $display("FAIL mid_seal_reset press=%0b enable=%0b required 0, 0", PRESS, ENABLE);
    end
    RESET = 1'b0;
    repeat (8) tick();
    checks++;
    if (cnt !== 7'd20) begin
      errors++;
      $display("FAIL mid_seal_count count=%0d required 20", cnt);
    end
    check_drained("mid_seal");
  endtask

  task automatic test_back_to_back();
    int n1, n2; bit g1, g2; logic r1, r2;
    apply_reset(7'd10);
    seal_bottle(7'd10, n1, g1, r1);
    BOTTLE_PRESENT = 1'b0;
    tick(); tick();
    seal_bottle(7'd9, n2, g2, r2);
    BOTTLE_PRESENT = 1'b0;
    tick(); tick();
    checks++;
    if (g1 !== 1'b1 || g2 !== 1'b1 || n1 != 4 || n2 != 4 || cnt !== 7'd8) begin
      errors++;
      $display("FAIL back_to_back got=%0b/%0b press=%0d/%0d count=%0d required 1/1, 4/4, 8",
               g1, g2, n1, n2, cnt);
    end
    check_drained("back_to_back");
  endtask

  initial begin
    test_reset();
    test_single_seal();
    test_stall();
    test_saturation();
    test_refill_during_seal();
    test_low_stock();
    test_reset_mid_seal();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cork_seal_controller.md
Name: cork_seal_controller

Overview:
- Sealing-station sequencer that sits directly around the cork counter. It drives the counter's decrement (ENABLE), load (LOAD) and load value (DADOS), and consumes the counter's COUNT and ZERO outputs.
- Per bottle, it runs the cork press and then issues exactly one decrement pulse.
- It services operator refill requests by loading the saturated sum COUNT + qty.
- It halts the line when the magazine is empty.

Parameters:
- WIDTH, 7, width of cork count, DADOS and REFILL_QTY.
- MAX_CORKS, 99, magazine capacity; refill sums saturate here.
- LOW_THRESH, 5, LOW_STOCK asserts when COUNT <= LOW_THRESH.
- SEAL_CYCLES, 4, number of cycles PRESS is held per bottle (>=1).

Ports:
- CLOCK  input  1  system clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- BOTTLE_PRESENT  input  1  level from the position sensor; synchronised and debounced upstream.
- REFILL_REQ  input  1  operator refill request, sampled every cycle.
- REFILL_QTY  input  WIDTH  corks added; captured in the cycle REFILL_REQ is sampled high.
- COUNT  input  WIDTH  current count from the cork counter.
- ZERO  input  1  counter-empty flag from the cork counter.
- ENABLE  output  1  one-cycle decrement pulse to the counter.
- LOAD  output  1  one-cycle load pulse to the counter.
- DADOS  output  WIDTH  load value; valid while LOAD=1, otherwise held.
- PRESS  output  1  cork press actuator.
- BOTTLE_RELEASE  output  1  one-cycle pulse telling the conveyor the bottle is done.
- LOW_STOCK  output  1  magazine low warning.
- HALT  output  1  bottle waiting with an empty magazine.

Behaviour:
- Reset is synchronous, active-high, single clock. While RESET=1 at a rising edge, the following take effect at that edge:
  - state=IDLE, pending refill cleared, captured qty=0;
  - ENABLE=0, LOAD=0, DADOS=0, PRESS=0, BOTTLE_RELEASE=0, HALT=0;
  - seal timer=0.
- LOW_STOCK is combinational: (COUNT <= LOW_THRESH) && !ZERO. All other outputs decode from registered state.
- The counter updates on the same edge that ends an ENABLE or LOAD cycle, so COUNT/ZERO are valid in the next cycle.
- States and transitions:
  - IDLE:
    - if pending refill or REFILL_REQ -> REFILL (refill has priority over a bottle);
    - else if BOTTLE_PRESENT && ZERO -> STALL;
    - else if BOTTLE_PRESENT -> SEAL.
  - SEAL:
    - PRESS=1 for exactly SEAL_CYCLES cycles, then -> CONSUME.
  - CONSUME:
    - one cycle with ENABLE=1 and BOTTLE_RELEASE=1 -> WAIT_CLEAR.
  - WAIT_CLEAR:
    - stays until BOTTLE_PRESENT=0, then -> IDLE (one bottle gets exactly one seal).
  - STALL:
    - HALT=1, PRESS=0, ENABLE=0;
    - REFILL_REQ -> REFILL;
    - BOTTLE_PRESENT=0 -> IDLE.
  - REFILL:
    - sum = COUNT + qty, computed in WIDTH+1 bits; DADOS = min(sum, MAX_CORKS);
    - LOAD=1 for one cycle, pending cleared -> IDLE;
    - if qty=0: no LOAD, pending cleared -> IDLE.
- Refill capture:
  - REFILL_REQ sampled high in SEAL, CONSUME or WAIT_CLEAR sets pending and captures REFILL_QTY.
  - A later request overwrites qty. Pending is serviced in the first IDLE cycle.
  - In IDLE/STALL, qty is captured the cycle REFILL_REQ is seen and used in the REFILL cycle.
- Invariants:
  - ENABLE and LOAD are never high in the same cycle.
  - ENABLE is never high when ZERO was high at SEAL entry.
  - PRESS is never high outside SEAL.
- A bottle removed during SEAL does not abort the sequence; it completes through CONSUME.
- Reset mid-operation: outputs drop at the reset edge, no ENABLE is issued for the interrupted bottle, and pending is lost.

Test Plan:
- Reset; counter at 99; BOTTLE_PRESENT=1 → PRESS high 4 cycles; then ENABLE=1 and BOTTLE_RELEASE=1 for 1 cycle; COUNT=98; no further ENABLE until BOTTLE_PRESENT falls and rises again.
- COUNT=0, BOTTLE_PRESENT=1 → HALT=1, PRESS=0, ENABLE=0 indefinitely. Then REFILL_REQ with qty=30 → LOAD 1 cycle with DADOS=30. Seal then proceeds and COUNT ends at 29.
- Saturation:
  - COUNT=90, refill qty=20 → DADOS=99.
  - COUNT=99, qty=127 → DADOS=99.
  - qty=0 → no LOAD.
- REFILL_REQ (qty=10) pulsed during SEAL at COUNT=50 → seal completes (COUNT=49). After the bottle clears, LOAD in the first IDLE cycle with DADOS=59. ENABLE and LOAD are never coincident.
- LOW_STOCK sweep → high at COUNT=5 and COUNT=1, low at 6 and at 0 (HALT path).
- RESET asserted in the 2nd SEAL cycle → at that edge PRESS=0 and state=IDLE; no ENABLE pulse; COUNT unchanged.
